// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over a
// req/ready handshake and holds it for decode until the instruction completes.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PcSrc,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        instr_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        misalign
);
  typedef enum logic {FETCH, ISSUE} state_t;
  state_t state;

  logic [31:0] pc4, brOff, nextPc;

  assign pc4       = pc + 32'd4;
  assign pc_plus8  = pc + 32'd8;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH) && !reset;
  assign brOff     = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    nextPc = pc4;
    case (PcSrc)
      2'd1: nextPc = zero ? pc4 + brOff : pc4;
      2'd2: nextPc = {pc4[31:28], instr[25:0], 2'b00};
      2'd3: nextPc = {rs_data[31:2], 2'b00};
      default: nextPc = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (instr_done) begin
          pc          <= nextPc;
          instr_valid <= 1'b0;
          state       <= FETCH;
          // sticky: a misaligned jr target is reported until the next reset
          if (PcSrc == 2'd3 && rs_data[1:0] != 2'b00) misalign <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed table, reset corners, and a
// randomized run against a transaction-level next-PC model.
module tb_ifu_fetch;
  logic        clk = 0;
  logic        reset;
  logic [1:0]  PcSrc;
  logic        zero;
  logic [31:0] rs_data;
  logic        instr_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        misalign;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .PcSrc(PcSrc), .zero(zero), .rs_data(rs_data),
    .instr_done(instr_done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus8(pc_plus8), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] curPc;
  logic        curMis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Next PC from the ISA rules, using plain integer arithmetic mod 2^32.
  function automatic logic [31:0] refNext(input logic [31:0] p, input logic [31:0] w,
                                          input logic [1:0] src, input logic z,
                                          input logic [31:0] rs);
    longint off;
    logic [31:0] r;
    off = longint'($signed(w[15:0])) * 4;
    case (src)
      2'd0: r = p + 32'd4;
      2'd1: r = z ? 32'(longint'(p) + 4 + off) : p + 32'd4;
      2'd2: r = ((p + 32'd4) & 32'hF000_0000) | 32'(longint'(w & 32'h03FF_FFFF) * 4);
      default: r = rs & 32'hFFFF_FFFC;
    endcase
    return r;
  endfunction

  // One full instruction: fetch with lat wait cycles, issue held for hold cycles.
  task automatic doInstr(input logic [31:0] word, input int lat, input int hold,
                         input logic [1:0] src, input logic z, input logic [31:0] rs,
                         input logic [31:0] expPc, input logic expMis);
    for (int i = 0; i <= lat; i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, curPc);
      chk("fetch_valid", 32'(instr_valid), 32'd0);
      imem_ready = (i == lat);
      imem_rdata = (i == lat) ? word : $urandom;
      @(negedge clk);
    end
    imem_ready = 0;
    for (int h = 0; h <= hold; h++) begin
      chk("issue_valid", 32'(instr_valid), 32'd1);
      chk("issue_instr", instr, word);
      chk("issue_pc", pc, curPc);
      chk("issue_req", 32'(imem_req), 32'd0);
      if (h == hold) begin
        instr_done = 1; PcSrc = src; zero = z; rs_data = rs;
        imem_ready = 0;
      end else begin
        instr_done = 0; PcSrc = 2'($urandom); zero = 1'($urandom); rs_data = $urandom;
        imem_ready = 1'($urandom); imem_rdata = $urandom;
      end
      @(negedge clk);
    end
    instr_done = 0; imem_ready = 0;
    PcSrc = 2'($urandom); zero = 1'($urandom); rs_data = $urandom;
    curPc = expPc;
    curMis = expMis;
    chk("next_pc", pc, expPc);
    chk("pc_plus8", pc_plus8, expPc + 32'd8);
    chk("misalign", 32'(misalign), 32'(expMis));
    chk("after_valid", 32'(instr_valid), 32'd0);
    chk("after_instr", instr, word);
  endtask

  typedef struct {
    logic [31:0] word;
    int          lat;
    int          hold;
    logic [1:0]  src;
    logic        z;
    logic [31:0] rs;
    logic [31:0] expPc;
    logic        expMis;
  } vec_t;

  vec_t vecs[12];

  task automatic doReset();
    reset = 1; instr_done = 0; imem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    reset = 0;
    #1;
    curPc = 32'h3000; curMis = 0;
  endtask

  initial begin
    reset = 1; PcSrc = 0; zero = 0; rs_data = 0; instr_done = 0;
    imem_rdata = 0; imem_ready = 0;
    vecs[0]  = '{32'h3C01_1234, 0, 0, 2'd0, 1'b0, 32'h0,         32'h0000_3004, 1'b0};
    vecs[1]  = '{32'h0800_0C04, 0, 0, 2'd2, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[2]  = '{32'h1000_FFFC, 0, 0, 2'd1, 1'b1, 32'h0,         32'h0000_3004, 1'b0};
    vecs[3]  = '{32'h0800_0C04, 1, 0, 2'd2, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[4]  = '{32'h1000_FFFC, 0, 1, 2'd1, 1'b0, 32'h0,         32'h0000_3014, 1'b0};
    vecs[5]  = '{32'h0800_0C08, 0, 0, 2'd2, 1'b0, 32'h0,         32'h0000_3020, 1'b0};
    vecs[6]  = '{32'h0800_0C40, 0, 0, 2'd2, 1'b0, 32'h0,         32'h0000_3100, 1'b0};
    vecs[7]  = '{32'h03E0_0008, 0, 0, 2'd3, 1'b0, 32'h0000_3046, 32'h0000_3044, 1'b1};
    vecs[8]  = '{32'h2001_0005, 3, 2, 2'd0, 1'b0, 32'h0,         32'h0000_3048, 1'b1};
    vecs[9]  = '{32'h03E0_0008, 0, 0, 2'd3, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
    vecs[10] = '{32'h0000_0000, 0, 0, 2'd0, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{32'h1000_FFFC, 1, 1, 2'd1, 1'b1, 32'h0,         32'hFFFF_FFF4, 1'b1};

    doReset();
    foreach (vecs[i])
      doInstr(vecs[i].word, vecs[i].lat, vecs[i].hold, vecs[i].src, vecs[i].z,
              vecs[i].rs, vecs[i].expPc, vecs[i].expMis);

    // reset during a FETCH wait while memory is ready: word must not be captured
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; reset = 1;
    #1 chk("rstwait_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("rstwait_valid", 32'(instr_valid), 32'd0);
    chk("rstwait_pc", pc, 32'h3000);
    chk("rstwait_instr", instr, 32'd0);
    chk("rstwait_mis", 32'(misalign), 32'd0);
    reset = 0; imem_ready = 0;
    #1;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h3000);
    curPc = 32'h3000; curMis = 0;

    // reset mid-ISSUE abandons the instruction
    doInstr(32'h1234_5678, 0, 0, 2'd0, 1'b0, 32'h0, 32'h3004, 1'b0);
    imem_ready = 1; imem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    imem_ready = 0; reset = 1; instr_done = 1;
    @(negedge clk);
    chk("rstissue_valid", 32'(instr_valid), 32'd0);
    chk("rstissue_pc", pc, 32'h3000);
    instr_done = 0;
    doReset();

    // randomized run against the model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] w, rs, np;
      logic [1:0]  src;
      logic        z, mis;
      w = $urandom; rs = $urandom; src = 2'($urandom); z = 1'($urandom);
      np  = refNext(curPc, w, src, z, rs);
      mis = curMis | (src == 2'd3 && (rs % 4) != 0);
      doInstr(w, $urandom_range(0, 3), $urandom_range(0, 2), src, z, rs, np, mis);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
